// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the writeback-select priority encoding.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int LINK_REG = 31;

    localparam logic [2:0] WB_SEL_LINK = 3'd0;
    localparam logic [2:0] WB_SEL_LUI  = 3'd1;
    localparam logic [2:0] WB_SEL_MEMB = 3'd2;
    localparam logic [2:0] WB_SEL_MEMW = 3'd3;
    localparam logic [2:0] WB_SEL_ALU  = 3'd4;

    // Fixed priority: link beats lui beats byte load beats word load beats ALU.
    function automatic logic [2:0] wb_sel(input logic jal, input logic lui,
                                          input logic mem_to_reg, input logic lb);
        if (jal)                   return WB_SEL_LINK;
        else if (lui)              return WB_SEL_LUI;
        else if (mem_to_reg && lb) return WB_SEL_MEMB;
        else if (mem_to_reg)       return WB_SEL_MEMW;
        else                       return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/wb_select.sv
// Combinational writeback mux: link address, lui, sign-extended byte load, word load or ALU result.
module wb_select
    import cpu_pkg::*;
#(
    parameter int W      = 32,
    parameter int PC_INC = 1
) (
    input  logic         jal,
    input  logic         lui,
    input  logic         mem_to_reg,
    input  logic         lb,
    input  logic [W-1:0] pc,
    input  logic [W-1:0] imm,
    input  logic [W-1:0] alu,
    input  logic [W-1:0] mem_rdata,
    output logic [W-1:0] data
);

    logic [7:0] byte_sel;
    logic       unused_imm_hi;

    assign unused_imm_hi = ^imm[W-1:16];

    // The low address bits pick the byte lane, little-endian.
    always_comb begin
        byte_sel = 8'h00;
        case (alu[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        data = alu;
        case (wb_sel(jal, lui, mem_to_reg, lb))
            WB_SEL_LINK: data = pc + W'(PC_INC);
            WB_SEL_LUI:  data = W'({imm[15:0], 16'h0000});
            WB_SEL_MEMB: data = {{(W-8){byte_sel[7]}}, byte_sel};
            WB_SEL_MEMW: data = mem_rdata;
            default:     data = alu;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with stall/flush, writeback select and retire/load counters.
// Optional MEM_WB_FWD_EN adds combinational forwarding copies of the write port.
module mem_wb #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int REG_AW   = cpu_pkg::REG_AW,
    parameter int CNT_W    = 32,
    parameter int PC_INC   = 1,
    parameter int LINK_REG = cpu_pkg::LINK_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic [REG_AW-1:0] rw_i,
    input  logic              jal_i,
    input  logic              lui_i,
    input  logic              MemToReg_i,
    input  logic              Regwrite_i,
    input  logic              lb_i,
    input  logic [DATA_W-1:0] PC_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [DATA_W-1:0] ALU_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rw,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  load_cnt
`ifdef MEM_WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rw,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] sel_data;
    logic              capture;

    assign dest    = jal_i ? REG_AW'(LINK_REG) : rw_i;
    assign capture = !flush && !stall;

    wb_select #(
        .W      (DATA_W),
        .PC_INC (PC_INC)
    ) u_wb_select (
        .jal        (jal_i),
        .lui        (lui_i),
        .mem_to_reg (MemToReg_i),
        .lb         (lb_i),
        .pc         (PC_i),
        .imm        (Imm_i),
        .alu        (ALU_i),
        .mem_rdata  (mem_rdata_i),
        .data       (sel_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rw    <= '0;
            wb_data  <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rw    <= '0;
            wb_data  <= '0;
        end else if (!stall) begin
            wb_valid <= in_valid;
            // r0 is hardwired zero, so writes to it are dropped here.
            wb_we    <= in_valid && Regwrite_i && (dest != '0);
            wb_rw    <= dest;
            wb_data  <= sel_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
            load_cnt   <= '0;
        end else if (clr_cnt) begin
            retire_cnt <= '0;
            load_cnt   <= '0;
        end else if (capture && in_valid) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
            if (MemToReg_i)
                load_cnt <= load_cnt + CNT_W'(1);
        end
    end

`ifdef MEM_WB_FWD_EN
    assign fwd_valid = wb_we;
    assign fwd_rw    = wb_rw;
    assign fwd_data  = wb_data;
`endif

endmodule
